busca_instrucao: RTL and testbench

Instruction-fetch unit that sits between the program-counter register and instruction memory. It owns the fetch address and issues word reads over a req/ack handshake. It holds each fetched instruction until the decoder consumes it, then computes the next address: sequential, or the branch target. It drives `proximo` and a load strobe so the PC register mirrors the address being fetched.

---
 rtl/busca_instrucao.sv | 141 ++++++++++++++
 tb/tb_busca_instrucao.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/busca_instrucao.sv
// -----------------------------------------------------------------------------
// busca_instrucao
// Instruction-fetch unit between the PC register and instruction memory.
// Owns the fetch address, issues word reads over a level req/ack handshake,
// holds each fetched word until the decoder consumes it, then computes the
// next fetch address (sequential or branch target) and strobes the PC
// register to load it.  A request left unacknowledged is abandoned and
// retried at the same address.
//
// Ports
//   clock, resetn            : clock, asynchronous active-low reset
//   mem_req, mem_addr        : registered read request and word address
//   mem_ack, mem_dado        : memory acknowledge and returned instruction
//   instrucao, instr_valida  : held instruction and its valid flag
//   consumir, desvio, alvo   : decoder accept, branch taken, branch target
//   proximo, avancar         : next fetch address and PC-load strobe
//   erro                     : one-cycle strobe on request timeout
// -----------------------------------------------------------------------------
module busca_instrucao #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clock,
   input  logic                  resetn,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_dado,
   output logic [DATA_WIDTH-1:0] instrucao,
   output logic                  instr_valida,
   input  logic                  consumir,
   input  logic                  desvio,
   input  logic [ADDR_WIDTH-1:0] alvo,
   output logic [ADDR_WIDTH-1:0] proximo,
   output logic                  avancar,
   output logic                  erro
);

   typedef enum logic [1:0] {
      REPOUSO,
      BUSCA,
      PRONTO
   } estado_t;

   localparam logic [7:0] LIMITE = 8'(TIMEOUT);

   estado_t               estado, estado_d;
   logic [7:0]            cont, cont_d;
   logic                  mem_req_d;
   logic [ADDR_WIDTH-1:0] mem_addr_d;
   logic [DATA_WIDTH-1:0] instrucao_d;
   logic                  instr_valida_d;
   logic [ADDR_WIDTH-1:0] proximo_d;
   logic                  avancar_d;
   logic                  erro_d;

   // Next-state and next-output computation.  Every output is registered, so
   // this block only decides what each register holds after the next edge.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned; a missing default here would infer a latch.
      estado_d       = estado;
      cont_d         = cont;
      mem_req_d      = mem_req;
      mem_addr_d     = mem_addr;
      instrucao_d    = instrucao;
      instr_valida_d = instr_valida;
      proximo_d      = proximo;
      avancar_d      = 1'b0;
      erro_d         = 1'b0;

      unique case (estado)
         REPOUSO: begin
            // mem_addr only ever changes here, on entry to BUSCA, so it is
            // stable for the whole request.
            estado_d   = BUSCA;
            mem_req_d  = 1'b1;
            mem_addr_d = proximo;
            cont_d     = '0;
         end

         BUSCA: begin
            if (mem_ack) begin
               instrucao_d    = mem_dado;
               instr_valida_d = 1'b1;
               mem_req_d      = 1'b0;
               estado_d       = PRONTO;
            end else if (cont == LIMITE) begin
               // Request has been up TIMEOUT+1 cycles; dropping it for one
               // cycle spaces retries TIMEOUT+2 cycles apart.  proximo is
               // untouched, so REPOUSO re-requests the same address.
               erro_d    = 1'b1;
               mem_req_d = 1'b0;
               estado_d  = REPOUSO;
            end else begin
               cont_d = cont + 8'd1;
            end
         end

         PRONTO: begin
            if (consumir) begin
               instr_valida_d = 1'b0;
               avancar_d      = 1'b1;
               // Wraps modulo 2**ADDR_WIDTH by construction.
               proximo_d      = desvio ? alvo : mem_addr + 1'b1;
               estado_d       = REPOUSO;
            end
         end

         default: estado_d = REPOUSO;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         estado       <= REPOUSO;
         cont         <= '0;
         mem_req      <= 1'b0;
         mem_addr     <= '0;
         instrucao    <= '0;
         instr_valida <= 1'b0;
         proximo      <= '0;
         avancar      <= 1'b0;
         erro         <= 1'b0;
      end else begin
         estado       <= estado_d;
         cont         <= cont_d;
         mem_req      <= mem_req_d;
         mem_addr     <= mem_addr_d;
         instrucao    <= instrucao_d;
         instr_valida <= instr_valida_d;
         proximo      <= proximo_d;
         avancar      <= avancar_d;
         erro         <= erro_d;
      end
   end

endmodule

// File: tb/tb_busca_instrucao.sv
// -----------------------------------------------------------------------------
// tb_busca_instrucao
// Directed bench for busca_instrucao (default parameters: 32-bit words,
// 6-bit addresses, TIMEOUT 15).  Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_busca_instrucao;

   logic        clock;
   logic        resetn;
   logic        mem_req;
   logic [5:0]  mem_addr;
   logic        mem_ack;
   logic [31:0] mem_dado;
   logic [31:0] instrucao;
   logic        instr_valida;
   logic        consumir;
   logic        desvio;
   logic [5:0]  alvo;
   logic [5:0]  proximo;
   logic        avancar;
   logic        erro;

   int checks = 0;
   int errors = 0;

   busca_instrucao dut (
      .clock        (clock),
      .resetn       (resetn),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_dado     (mem_dado),
      .instrucao    (instrucao),
      .instr_valida (instr_valida),
      .consumir     (consumir),
      .desvio       (desvio),
      .alvo         (alvo),
      .proximo      (proximo),
      .avancar      (avancar),
      .erro         (erro)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] palavra(input logic [5:0] a);
      return 32'hA000_0000 | {26'd0, a};
   endfunction

   // Entered in the first BUSCA cycle of a request at addr_exp.  Acks with no
   // wait, consumes with the given branch inputs, and leaves the bench in the
   // first BUSCA cycle of the following request.
   task automatic fetch(input logic [5:0] addr_exp, input logic des,
                        input logic [5:0] tgt, input logic [5:0] prox_exp,
                        input logic keep);
      check("req_up", mem_req, 1'b1);
      check("addr", mem_addr, addr_exp);
      mem_ack  = 1'b1;
      mem_dado = palavra(addr_exp);
      consumir = keep;
      step();
      mem_ack  = 1'b0;
      mem_dado = 32'h0;
      check("valida", instr_valida, 1'b1);
      check("instrucao", instrucao, palavra(addr_exp));
      check("req_down", mem_req, 1'b0);
      check("avancar_idle", avancar, 1'b0);
      consumir = 1'b1;
      desvio   = des;
      alvo     = tgt;
      step();
      consumir = keep;
      desvio   = 1'b0;
      alvo     = 6'd0;
      check("avancar", avancar, 1'b1);
      check("proximo", proximo, prox_exp);
      check("valida_clr", instr_valida, 1'b0);
      check("erro_quiet", erro, 1'b0);
      step();
      check("avancar_pulse", avancar, 1'b0);
      check("req_next", mem_req, 1'b1);
      check("addr_next", mem_addr, prox_exp);
   endtask

   // Entered in the first BUSCA cycle of a request that will never be acked.
   // Returns the number of edges until erro is observed.
   task automatic wait_erro(input logic [5:0] addr_exp, output int n);
      n = 0;
      while (erro !== 1'b1 && n < 40) begin
         check("to_req", mem_req, 1'b1);
         check("to_addr", mem_addr, addr_exp);
         step();
         n++;
      end
      if (erro !== 1'b1) check("erro_bound", erro, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] held;

      resetn   = 1'b0;
      mem_ack  = 1'b0;
      mem_dado = 32'h0;
      consumir = 1'b0;
      desvio   = 1'b0;
      alvo     = 6'd0;

      // Reset state
      #12;
      check("rst_req", mem_req, 1'b0);
      check("rst_valida", instr_valida, 1'b0);
      check("rst_avancar", avancar, 1'b0);
      check("rst_erro", erro, 1'b0);
      check("rst_addr", mem_addr, 6'd0);
      check("rst_proximo", proximo, 6'd0);
      check("rst_instrucao", instrucao, 32'h0);

      @(negedge clock);
      resetn = 1'b1;
      step();
      // Cycle 1: first request at address 0
      check("c1_req", mem_req, 1'b1);
      check("c1_addr", mem_addr, 6'd0);

      // Zero-wait memory with consumir held high: addresses 0..3
      for (int i = 0; i < 4; i++)
         fetch(6'(i), 1'b0, 6'd0, 6'(i + 1), 1'b1);
      consumir = 1'b0;
      fetch(6'd4, 1'b0, 6'd0, 6'd5, 1'b0);

      // Four wait states at address 5
      for (int w = 0; w < 4; w++) begin
         step();
         check("ws_req", mem_req, 1'b1);
         check("ws_addr", mem_addr, 6'd5);
         check("ws_valida", instr_valida, 1'b0);
         check("ws_erro", erro, 1'b0);
      end
      fetch(6'd5, 1'b0, 6'd0, 6'd6, 1'b0);

      // Branch taken and not taken at address 7
      fetch(6'd6, 1'b0, 6'd0, 6'd7, 1'b0);
      fetch(6'd7, 1'b1, 6'd40, 6'd40, 1'b0);
      fetch(6'd40, 1'b1, 6'd7, 6'd7, 1'b0);
      fetch(6'd7, 1'b0, 6'd40, 6'd8, 1'b0);

      // Wrap from the top address
      fetch(6'd8, 1'b1, 6'd63, 6'd63, 1'b0);
      fetch(6'd63, 1'b0, 6'd0, 6'd0, 1'b0);

      // Timeout: no ack at address 0
      wait_erro(6'd0, n);
      check("to_edges1", n, 16);
      check("to_req_low", mem_req, 1'b0);
      check("to_no_avancar", avancar, 1'b0);
      // Late ack in the retry cycle must be ignored
      mem_ack  = 1'b1;
      mem_dado = 32'hDEAD_BEEF;
      step();
      mem_ack  = 1'b0;
      mem_dado = 32'h0;
      check("retry_req", mem_req, 1'b1);
      check("retry_erro_pulse", erro, 1'b0);
      check("retry_valida", instr_valida, 1'b0);
      // Second timeout: erro-to-erro spacing is 1 + 16 = 17 cycles
      wait_erro(6'd0, n);
      check("to_edges2", n, 16);
      step();
      check("retry2_erro", erro, 1'b0);
      // Ack on the re-request completes normally
      fetch(6'd0, 1'b0, 6'd0, 6'd1, 1'b0);

      // Async reset mid-fetch at address 12
      fetch(6'd1, 1'b1, 6'd12, 6'd12, 1'b0);
      #1;
      resetn = 1'b0;
      #1;
      check("arst_req", mem_req, 1'b0);
      check("arst_valida", instr_valida, 1'b0);
      check("arst_proximo", proximo, 6'd0);
      check("arst_addr", mem_addr, 6'd0);
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b1;
      step();
      check("resume_req", mem_req, 1'b1);
      check("resume_addr", mem_addr, 6'd0);

      // Hold in PRONTO for 10 cycles with consumir low; stray acks ignored
      mem_ack  = 1'b1;
      mem_dado = 32'h1234_5678;
      step();
      held     = 32'h1234_5678;
      check("hold_valida0", instr_valida, 1'b1);
      check("hold_instr0", instrucao, held);
      mem_dado = 32'hBEEF_0000;
      for (int c = 0; c < 10; c++) begin
         step();
         check("hold_instr", instrucao, held);
         check("hold_valida", instr_valida, 1'b1);
         check("hold_req", mem_req, 1'b0);
         check("hold_avancar", avancar, 1'b0);
      end
      mem_ack  = 1'b0;
      mem_dado = 32'h0;
      consumir = 1'b1;
      step();
      consumir = 1'b0;
      check("hold_done_avancar", avancar, 1'b1);
      check("hold_done_proximo", proximo, 6'd1);
      step();
      check("hold_next_addr", mem_addr, 6'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
